// File: rtl/divu_hilo_unit_pkg.sv
// Shared ALU-control / divider definitions: function codes and divider FSM state encoding.
package divu_hilo_unit_pkg;

    localparam logic [5:0] F_DIVU      = 6'b011011;
    localparam logic [5:0] F_MFHI      = 6'b010000;
    localparam logic [5:0] F_MFLO      = 6'b010010;
    localparam logic [5:0] F_HILO_OPEN = 6'b111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } divu_state_t;

    function automatic logic is_divu(input logic [5:0] code);
        return code == F_DIVU;
    endfunction

endpackage

// File: rtl/divu_core.sv
// Iterative restoring unsigned divider: one quotient bit per cycle after a start pulse.
// Optional DIVU_DZ_FLAG_EN adds a divisor_zero output for the captured divisor.
module divu_core
    import divu_hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIVU_DZ_FLAG_EN
    ,
    output logic             divisor_zero
`endif
);

    // The settled remainder is always below the divisor, so WIDTH bits hold it;
    // the extra bit only exists in the shifted trial window.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [WIDTH:0]   shifted;
    logic             fits;

    assign shifted   = {rem, quo[WIDTH-1]};
    assign fits      = shifted >= {1'b0, dvs};
    assign last      = running && (cnt == CNT_W'(WIDTH - 1));
    assign busy      = running;
    assign quotient  = quo;
    assign remainder = rem;

`ifdef DIVU_DZ_FLAG_EN
    assign divisor_zero = (dvs == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem     <= '0;
            quo     <= dividend;
            dvs     <= divisor;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (fits) begin
                rem <= WIDTH'(shifted - {1'b0, dvs});
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/divu_hilo_unit.sv
// Execute-stage DIVU unit: control FSM, HI/LO registers and MFHI/MFLO read mux.
// Optional DIVU_DZ_FLAG_EN adds a sticky-until-next-start divide-by-zero flag.
module divu_hilo_unit
    import divu_hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       ctrl_sig,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] result_out
`ifdef DIVU_DZ_FLAG_EN
    ,
    output logic             dz_flag
`endif
);

    divu_state_t      state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             start;
    logic             core_busy;
    logic             core_last;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;
`ifdef DIVU_DZ_FLAG_EN
    logic             core_dz;
`endif

    assign start  = (state == IDLE) && is_divu(ctrl_sig);
    assign busy   = core_busy || (state == COMMIT);
    assign hi_out = hi;
    assign lo_out = lo;

    divu_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (core_busy),
        .last         (core_last),
        .quotient     (core_quo),
        .remainder    (core_rem)
`ifdef DIVU_DZ_FLAG_EN
        ,
        .divisor_zero (core_dz)
`endif
    );

    // HOLD waits for the code to leave DIVU so a long DIVU runs only one divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (core_last) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    hi    <= core_rem;
                    lo    <= core_quo;
                    done  <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (!is_divu(ctrl_sig)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIVU_DZ_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_flag <= 1'b0;
        end else if (start) begin
            dz_flag <= 1'b0;
        end else if (state == COMMIT) begin
            dz_flag <= core_dz;
        end
    end
`endif

    // Reads are not stalled here: a read during a divide sees the previous HI/LO.
    always_comb begin
        result_out = '0;
        case (ctrl_sig)
            F_MFHI:      result_out = hi;
            F_MFLO:      result_out = lo;
            F_HILO_OPEN: result_out = '0;
            default:     result_out = '0;
        endcase
    end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Scoreboard bench for divu_hilo_unit: stimulus queues expected HI/LO, a monitor checks on done.
module tb_divu_hilo_unit;
    import divu_hilo_unit_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dz;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       ctrl_sig = 6'h00;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] result_out;
`ifdef DIVU_DZ_FLAG_EN
    logic             dz_flag;
`endif

    exp_t             exp_q[$];
    int               tests = 0;
    int               fails = 0;
    int               done_count = 0;
    logic [WIDTH-1:0] last_hi = '0;
    logic [WIDTH-1:0] last_lo = '0;

    divu_hilo_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_sig   (ctrl_sig),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .result_out (result_out)
`ifdef DIVU_DZ_FLAG_EN
        ,
        .dz_flag    (dz_flag)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.hi = a;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check_output(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding divide.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending divide");
            end else begin
                e = exp_q.pop_front();
                check_output("hi_on_done", hi_out, e.hi);
                check_output("lo_on_done", lo_out, e.lo);
`ifdef DIVU_DZ_FLAG_EN
                check_output("dz_on_done", {31'b0, dz_flag}, {31'b0, e.dz});
`endif
            end
        end
    end

    // mode: 0 plain, 1 MFHI at RUN cycle 5, 2 zero operands at RUN cycle 5, 3 reset at RUN cycle 10
    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input int hold, input int mode);
        exp_t e;
        int   busy_cycles = 0;
        int   start_done;
        bit   restarted = 0;
        e = model(a, b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        ctrl_sig = F_DIVU;
        if (mode != 3) exp_q.push_back(e);
        start_done = done_count;
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            busy_cycles++;
            if (mode == 1 && busy_cycles == 5) begin
                ctrl_sig = F_MFHI;
                #1 check_output("mfhi_while_busy", result_out, last_hi);
            end
            if (mode == 2 && busy_cycles == 5) begin
                dividend = '0;
                divisor  = '0;
                ctrl_sig = 6'h00;
            end
            if (mode == 3 && busy_cycles == 10) begin
                rst_n = 1'b0;
                #1;
                check_output("abort_busy", {31'b0, busy}, 32'd0);
                check_output("abort_done", {31'b0, done}, 32'd0);
                check_output("abort_hi", hi_out, '0);
                check_output("abort_lo", lo_out, '0);
                break;
            end
            @(negedge clk);
        end
        if (mode == 3) begin
            repeat (2) @(negedge clk);
            ctrl_sig = 6'h00;
            rst_n    = 1'b1;
            last_hi  = '0;
            last_lo  = '0;
            repeat (3) @(negedge clk);
            check_output("abort_idle", {31'b0, busy}, 32'd0);
            check_output("abort_no_done", 32'(done_count - start_done), 32'd0);
        end else begin
            check_output("busy_cycles", 32'(busy_cycles), 32'd33);
            check_output("done_latency", {31'b0, done}, 32'd1);
            last_hi = e.hi;
            last_lo = e.lo;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (busy) restarted = 1;
            end
            check_output("no_restart", {31'b0, restarted}, 32'd0);
            ctrl_sig = 6'h00;
            repeat (2) @(negedge clk);
            check_output("done_pulses", 32'(done_count - start_done), 32'd1);
        end
    endtask

    task automatic check_reads();
        @(negedge clk);
        ctrl_sig = F_MFLO;
        #1 check_output("mflo", result_out, last_lo);
        ctrl_sig = F_MFHI;
        #1 check_output("mfhi", result_out, last_hi);
        ctrl_sig = F_HILO_OPEN;
        #1 check_output("hilo_open", result_out, '0);
        ctrl_sig = 6'h00;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        repeat (3) @(negedge clk);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_done", {31'b0, done}, 32'd0);
        check_output("reset_hi", hi_out, '0);
        check_output("reset_lo", lo_out, '0);
`ifdef DIVU_DZ_FLAG_EN
        check_output("reset_dz", {31'b0, dz_flag}, 32'd0);
`endif
        ctrl_sig = F_MFHI;
        #1 check_output("reset_result", result_out, '0);
        ctrl_sig = 6'h00;
        rst_n = 1'b1;

        apply_stimulus(32'd100, 32'd7, 40, 0);
        check_reads();
        apply_stimulus(32'hFFFF_FFFF, 32'd1, 0, 0);
        check_reads();
        apply_stimulus(32'h0000_1234, 32'd0, 2, 0);
`ifdef DIVU_DZ_FLAG_EN
        check_output("dz_set", {31'b0, dz_flag}, 32'd1);
`endif
        check_reads();
        apply_stimulus(32'd9, 32'd3, 0, 0);
`ifdef DIVU_DZ_FLAG_EN
        check_output("dz_cleared", {31'b0, dz_flag}, 32'd0);
`endif
        apply_stimulus(32'd50, 32'd8, 0, 1);
        check_reads();
        apply_stimulus(32'd1000, 32'd10, 0, 3);
        apply_stimulus(32'd1000, 32'd10, 0, 0);
        check_reads();
        apply_stimulus(32'd7, 32'd100, 0, 2);
        check_reads();

        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = WIDTH'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            apply_stimulus(a, b, $urandom_range(0, 3), 0);
            check_reads();
        end

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_queue: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
